// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot interface: FIFO-buffers plot strobes and issues one
// framebuffer write per cycle, plus a full-screen clear sweep. `define PLOT_CLIP_EN to drop off-screen plots.
module plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [2:0]                   colour,
  input  logic                         writeEn,
  input  logic                         clear,
  input  logic [2:0]                   clear_colour,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic [2:0]                   fb_data,
  output logic                         fb_wren,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LIN_W = 21;
  localparam int unsigned TOTAL = WIDTH * HEIGHT;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
  } plot_t;

  plot_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [1:0]         state, state_nxt;
  logic               pending, pending_nxt;
  logic [2:0]         clr_col, clr_col_nxt;
  logic [ADDR_W-1:0]  clr_addr, clr_addr_nxt;
  logic [ADDR_W-1:0]  fb_addr_nxt;
  logic [2:0]         fb_data_nxt;
  logic               fb_wren_nxt;
  logic               overflow_nxt;
  logic               busy_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               in_range, push_req, push, pop;
  plot_t              head;
  logic [LIN_W-1:0]   lin;

`ifdef PLOT_CLIP_EN
  assign in_range = (x < 10'(WIDTH)) && (y < 10'(HEIGHT));
`else
  assign in_range = 1'b1;
`endif

  // Next-state, FIFO control and registered-output values
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    clr_col_nxt  = clr_col;
    clr_addr_nxt = clr_addr;
    fb_addr_nxt  = fb_addr;
    fb_data_nxt  = fb_data;
    fb_wren_nxt  = 1'b0;
    overflow_nxt = overflow;
    pop          = 1'b0;

    push_req = writeEn && in_range;
    push     = push_req && (fifo_count != CNT_W'(DEPTH));
    head     = mem[rd_ptr];
    lin      = LIN_W'(head.y) * LIN_W'(WIDTH) + LIN_W'(head.x);

    case (state)
      IDLE: begin
        // A clear into an empty FIFO starts at once so a same-cycle plot lands after the sweep
        if (clear) begin
          clr_col_nxt = clear_colour;
          if (fifo_count == '0) begin
            state_nxt    = CLEAR;
            clr_addr_nxt = '0;
            pending_nxt  = 1'b0;
          end else begin
            pending_nxt = 1'b1;
            state_nxt   = DRAIN;
          end
        end else if (pending && (fifo_count == '0)) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
          pending_nxt  = 1'b0;
        end else if (fifo_count != '0) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pop         = (fifo_count != '0);
        fb_wren_nxt = pop;
        if (pop) begin
          fb_addr_nxt = ADDR_W'(lin);
          fb_data_nxt = head.colour;
        end
        if (clear) begin
          pending_nxt = 1'b1;
          clr_col_nxt = clear_colour;
        end
        if ((fifo_count <= CNT_W'(1)) && !push) state_nxt = IDLE;
      end
      CLEAR: begin
        fb_wren_nxt = 1'b1;
        fb_addr_nxt = clr_addr;
        fb_data_nxt = clr_col;
        if (clear) begin
          clr_addr_nxt = '0;
          clr_col_nxt  = clear_colour;
        end else if (clr_addr == ADDR_W'(TOTAL - 1)) begin
          state_nxt = IDLE;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A drop in the same cycle as a clear still leaves the flag set
    if (clear) overflow_nxt = 1'b0;
    if (push_req && !push) overflow_nxt = 1'b1;

    count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    busy_nxt  = (state_nxt != IDLE) || (count_nxt != '0) || pending_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pending    <= 1'b0;
      clr_col    <= '0;
      clr_addr   <= '0;
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_wren    <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      clr_col    <= clr_col_nxt;
      clr_addr   <= clr_addr_nxt;
      fb_addr    <= fb_addr_nxt;
      fb_data    <= fb_data_nxt;
      fb_wren    <= fb_wren_nxt;
      overflow   <= overflow_nxt;
      busy       <= busy_nxt;
      fifo_count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: x, y: y, colour: colour};
  end

endmodule

// File: tb/tb_plot_sink.sv
// Directed self-checking bench for plot_sink: plot latency, ordering, clear sweep,
// overflow, clipping and asynchronous reset mid-sweep.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        writeEn = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] wlog[$];

  plot_sink dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .clear(clear), .clear_colour(clear_colour), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_wren(fb_wren), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #10 clk = ~clk;

  // Write log, sampled mid-cycle
  always @(negedge clk) if (resetn === 1'b1 && fb_wren === 1'b1) wlog.push_back({fb_addr, fb_data});

  task automatic do_reset();
    resetn = 1'b0; writeEn = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (fb_wren !== 1'b0)    $display("FAIL reset_wren: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd0)   $display("FAIL reset_addr: got %0d want 0", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'd0)    $display("FAIL reset_data: got %0d want 0", fb_data); else n_pass++;
    n_checks++; if (overflow !== 1'b0)   $display("FAIL reset_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_plot();
    x = 10'd5; y = 10'd3; colour = 3'b101; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
    n_checks++; if (fifo_count !== 4'd1) $display("FAIL single_count: got %0d want 1", fifo_count); else n_pass++;
    n_checks++; if (fb_wren !== 1'b0)    $display("FAIL single_wren_n0: got %0b want 0", fb_wren); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b0)    $display("FAIL single_wren_n1: got %0b want 0", fb_wren); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b1)    $display("FAIL single_wren_n2: got %0b want 1", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd485) $display("FAIL single_addr: got %0d want 485", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'd5)    $display("FAIL single_data: got %0d want 5", fb_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b0)    $display("FAIL single_wren_after: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL single_busy_after: got %0b want 0", busy); else n_pass++;
    n_checks++; if (fb_addr !== 15'd485) $display("FAIL single_addr_hold: got %0d want 485", fb_addr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    x = 10'd0; y = 10'd0; colour = 3'd1; writeEn = 1'b1;
    @(negedge clk);
    x = 10'd159; y = 10'd119; colour = 3'd7;
    @(negedge clk);
    writeEn = 1'b0;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b1)      $display("FAIL b2b_wren0: got %0b want 1", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd0)     $display("FAIL b2b_addr0: got %0d want 0", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'd1)      $display("FAIL b2b_data0: got %0d want 1", fb_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b1)      $display("FAIL b2b_wren1: got %0b want 1", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd19199) $display("FAIL b2b_addr1: got %0d want 19199", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'd7)      $display("FAIL b2b_data1: got %0d want 7", fb_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b0)      $display("FAIL b2b_wren_after: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (busy !== 1'b0)         $display("FAIL b2b_busy_after: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_clear();
    int good;
    good = 0;
    clear = 1'b1; clear_colour = 3'd0;
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (busy !== 1'b1)    $display("FAIL clear_busy: got %0b want 1", busy); else n_pass++;
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL clear_wren_start: got %0b want 0", fb_wren); else n_pass++;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      if (fb_wren === 1'b1 && fb_addr === 15'(i) && fb_data === 3'd0) good++;
    end
    n_checks++; if (good !== 19200)   $display("FAIL clear_sweep: got %0d good writes want 19200", good); else n_pass++;
    @(negedge clk);
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL clear_wren_end: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (busy !== 1'b0)    $display("FAIL clear_busy_end: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    int n;
    logic [17:0] e;
    wlog.delete();
    clear = 1'b1; clear_colour = 3'd2;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      x = 10'(i); y = 10'd1; colour = 3'(i); writeEn = 1'b1;
      @(negedge clk);
    end
    writeEn = 1'b0;
    n_checks++; if (fifo_count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1)   $display("FAIL ovf_flag: got %0b want 1", overflow); else n_pass++;
    for (int c = 0; c < 25000 && busy !== 1'b0; c++) @(negedge clk);
    n_checks++; if (busy !== 1'b0)       $display("FAIL ovf_timeout: busy got %0b want 0", busy); else n_pass++;
    @(negedge clk);
    n = wlog.size();
    n_checks++; if (n !== 19208)         $display("FAIL ovf_nwrites: got %0d want 19208", n); else n_pass++;
    if (n >= 8) begin
      for (int i = 0; i < 8; i++) begin
        e = wlog[n - 8 + i];
        n_checks++;
        if (e !== {15'(160 + i), 3'(i)})
          $display("FAIL ovf_order%0d: got addr %0d data %0d want addr %0d data %0d", i, e[17:3], e[2:0], 160 + i, i);
        else n_pass++;
      end
    end
    n_checks++; if (overflow !== 1'b1)   $display("FAIL ovf_sticky: got %0b want 1", overflow); else n_pass++;
  endtask

  task automatic test_clip();
    logic [17:0] e;
    do_reset();
    wlog.delete();
    x = 10'd160; y = 10'd0; colour = 3'd6; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (overflow !== 1'b0) $display("FAIL clip_overflow: got %0b want 0", overflow); else n_pass++;
`ifdef PLOT_CLIP_EN
    n_checks++; if (wlog.size() !== 0) $display("FAIL clip_nwrites: got %0d want 0", wlog.size()); else n_pass++;
`else
    n_checks++; if (wlog.size() !== 1) $display("FAIL clip_nwrites: got %0d want 1", wlog.size()); else n_pass++;
    if (wlog.size() > 0) begin
      e = wlog[0];
      n_checks++; if (e !== {15'd160, 3'd6}) $display("FAIL clip_write: got addr %0d data %0d want addr 160 data 6", e[17:3], e[2:0]); else n_pass++;
    end
`endif
  endtask

  task automatic test_reset_midsweep();
    int n0;
    logic hit;
    hit = 1'b0;
    clear = 1'b1; clear_colour = 3'd4;
    x = 10'd1; y = 10'd1; colour = 3'd3; writeEn = 1'b1;
    @(negedge clk);
    clear = 1'b0; x = 10'd2;
    @(negedge clk);
    x = 10'd3;
    @(negedge clk);
    writeEn = 1'b0;
    n_checks++; if (fifo_count !== 4'd3) $display("FAIL rst_precount: got %0d want 3", fifo_count); else n_pass++;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      if (fb_wren === 1'b1 && fb_addr === 15'd1000) hit = 1'b1;
    end
    n_checks++; if (hit !== 1'b1)        $display("FAIL rst_reach1000: got %0b want 1", hit); else n_pass++;
    n_checks++; if (fb_data !== 3'd4)    $display("FAIL rst_sweepdata: got %0d want 4", fb_data); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (fb_wren !== 1'b0)    $display("FAIL rst_async_wren: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (fifo_count !== 4'd0) $display("FAIL rst_async_count: got %0d want 0", fifo_count); else n_pass++;
    n0 = wlog.size();
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++; if (wlog.size() !== n0)  $display("FAIL rst_no_writes: got %0d want %0d", wlog.size(), n0); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_back_to_back();
    test_clear();
    test_overflow();
    test_clip();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
